// File: rtl/zigzag_scan_ctrl.sv
// Zig-zag scan sequencer: walks an N x N row-major Rom in zig-zag order and streams elements on valid/ready.
// Optional macro ZIGZAG_COORD_EN adds registered out_row/out_col coordinate outputs.
module zigzag_scan_ctrl #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef ZIGZAG_COORD_EN
  ,
  output logic [$clog2(N)-1:0] out_row,
  output logic [$clog2(N)-1:0] out_col
`endif
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N * N) + 1;
  localparam logic [RW-1:0] LAST_RC  = RW'(N - 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N * N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  state_t            state_q;
  dir_t              dir_q;
  dir_t              dir_d;
  logic [RW-1:0]     row_q;
  logic [RW-1:0]     row_d;
  logic [RW-1:0]     col_q;
  logic [RW-1:0]     col_d;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic              adv;
  logic              is_last;

`ifdef ZIGZAG_COORD_EN
  logic [RW-1:0] out_row_q;
  logic [RW-1:0] out_col_q;
  assign out_row = out_row_q;
  assign out_col = out_col_q;
`endif

  // Address is truncated to the Rom width by the cast of each term.
  assign rom_addr  = ADDR_W'(row_q) * ADDR_W'(N) + ADDR_W'(col_q);
  assign adv       = !out_valid_q || out_ready;
  assign is_last   = (cnt_q == LAST_IDX);
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  // Next zig-zag coordinate; corner tests are ordered so the column/row edge wins over the origin edge.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    dir_d = dir_q;
    if (dir_q == DIR_UP) begin
      if (col_q == LAST_RC) begin
        row_d = row_q + RW'(1);
        dir_d = DIR_DOWN;
      end else if (row_q == '0) begin
        col_d = col_q + RW'(1);
        dir_d = DIR_DOWN;
      end else begin
        row_d = row_q - RW'(1);
        col_d = col_q + RW'(1);
      end
    end else begin
      if (row_q == LAST_RC) begin
        col_d = col_q + RW'(1);
        dir_d = DIR_UP;
      end else if (col_q == '0) begin
        row_d = row_q + RW'(1);
        dir_d = DIR_UP;
      end else begin
        row_d = row_q + RW'(1);
        col_d = col_q - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= DIR_UP;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef ZIGZAG_COORD_EN
      out_row_q   <= '0;
      out_col_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q <= S_SCAN;
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
          end
        end

        S_SCAN: begin
          if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
          end else if (adv) begin
            out_data_q  <= rom_data;
            out_valid_q <= 1'b1;
            out_last_q  <= is_last;
`ifdef ZIGZAG_COORD_EN
            out_row_q   <= row_q;
            out_col_q   <= col_q;
`endif
            cnt_q       <= cnt_q + CW'(1);
            if (is_last) begin
              state_q <= S_FLUSH;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
              dir_q <= dir_d;
            end
          end
        end

        S_FLUSH: begin
          if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
          end else if (out_ready) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_scan_ctrl.sv
// Randomized bench for zigzag_scan_ctrl against a diagonal-walk reference of the zig-zag order.
module tb_zigzag_scan_ctrl;

  localparam int N      = 8;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int NN     = N * N;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
`ifdef ZIGZAG_COORD_EN
  logic [$clog2(N)-1:0] out_row;
  logic [$clog2(N)-1:0] out_col;
`endif

  int total = 0;
  int bad   = 0;
  int ord_r [NN];
  int ord_c [NN];

  always #5 clk = ~clk;

  // Rom holds its own index.
  assign rom_data = DATA_W'(rom_addr);

  zigzag_scan_ctrl #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef ZIGZAG_COORD_EN
    ,
    .out_row   (out_row),
    .out_col   (out_col)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Zig-zag order as anti-diagonals: odd diagonals walk row upward from the top, even ones from the bottom.
  task automatic build_model();
    int k = 0;
    for (int d = 0; d <= 2 * N - 2; d++) begin
      int lo = (d - N + 1 > 0) ? d - N + 1 : 0;
      int hi = (d < N - 1) ? d : N - 1;
      if (d % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin
          ord_r[k] = r; ord_c[k] = d - r; k++;
        end
      end else begin
        for (int r = hi; r >= lo; r--) begin
          ord_r[k] = r; ord_c[k] = d - r; k++;
        end
      end
    end
  endtask

  function automatic logic ready_pick(input int mode, input int iter);
    if (mode == 1) return (iter % 2 == 0);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // mode: 0 ready always high, 1 ready toggling, 2 random ready with stray start pulses.
  task automatic run_scan(input string tag, input int mode, input bit hold_start,
                          input int abort_at, input int rst_at);
    int beat = 0;
    int iter = 0;
    int last_iter = -10;
    bit fin = 0;
    bit p_valid = 0;
    bit p_ready = 0;
    bit p_last = 0;
    logic [DATA_W-1:0] p_data = '0;
    start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    check({tag, "_busy_go"}, 32'(busy), 32'd1);
    check({tag, "_valid_go"}, 32'(out_valid), 32'd0);
    out_ready = ready_pick(mode, iter);
    while (!fin) begin
      @(negedge clk);
      iter++;
      if (iter == 1) check({tag, "_first_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_done"}, 32'(done), 32'(iter == last_iter + 1));
      if (mode == 0 && beat < NN) check({tag, "_tput"}, 32'(out_valid), 32'd1);
      if (p_valid && !p_ready) begin
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(out_data), 32'(p_data));
        check({tag, "_hold_last"}, 32'(out_last), 32'(p_last));
      end
      if (done) begin
        fin = 1;
        out_ready = 1'b0;
        if (!hold_start) start = 1'b0;
      end else if (iter > 400) begin
        check({tag, "_timeout"}, 32'(beat), 32'(NN));
        fin = 1;
      end else begin
        if (out_valid && beat == abort_at) begin
          out_ready = 1'b0; abort = 1'b1; start = 1'b0;
          @(negedge clk);
          abort = 1'b0;
          check({tag, "_abort_valid"}, 32'(out_valid), 32'd0);
          check({tag, "_abort_busy"}, 32'(busy), 32'd0);
          check({tag, "_abort_last"}, 32'(out_last), 32'd0);
          check({tag, "_abort_done"}, 32'(done), 32'd0);
          @(negedge clk);
          check({tag, "_abort_done2"}, 32'(done), 32'd0);
          check({tag, "_abort_idle"}, 32'(busy), 32'd0);
          $display("scan %s: aborted at beat %0d", tag, beat);
          return;
        end
        if (out_valid && beat == rst_at) begin
          out_ready = 1'b1; start = 1'b0;
          #2 rst = 1'b1;
          #1;
          check({tag, "_rst_busy"}, 32'(busy), 32'd0);
          check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
          check({tag, "_rst_last"}, 32'(out_last), 32'd0);
          check({tag, "_rst_data"}, 32'(out_data), 32'd0);
          check({tag, "_rst_addr"}, 32'(rom_addr), 32'd0);
          check({tag, "_rst_done"}, 32'(done), 32'd0);
          @(negedge clk);
          rst = 1'b0;
          $display("scan %s: reset at beat %0d", tag, beat);
          return;
        end
        out_ready = ready_pick(mode, iter);
        if (mode == 2 && !hold_start) start = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          check({tag, "_data"}, 32'(out_data), 32'(ord_r[beat] * N + ord_c[beat]));
          check({tag, "_last"}, 32'(out_last), 32'(beat == NN - 1));
`ifdef ZIGZAG_COORD_EN
          check({tag, "_row"}, 32'(out_row), 32'(ord_r[beat]));
          check({tag, "_col"}, 32'(out_col), 32'(ord_c[beat]));
          check({tag, "_rc_addr"}, 32'(out_row) * N + 32'(out_col), 32'(out_data));
`endif
          if (beat == NN - 1) last_iter = iter;
          beat++;
        end
        p_valid = out_valid; p_ready = out_ready; p_data = out_data; p_last = out_last;
      end
    end
    check({tag, "_beats"}, 32'(beat), 32'(NN));
    if (mode == 0) check({tag, "_last_cycle"}, 32'(last_iter), 32'(NN));
    if (hold_start) begin
      @(negedge clk);
      check({tag, "_restart_busy"}, 32'(busy), 32'd1);
      check({tag, "_restart_valid"}, 32'(out_valid), 32'd0);
      start = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check({tag, "_restart_abort"}, 32'(busy), 32'd0);
    end else begin
      @(negedge clk);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
    end
    $display("scan %s: beats=%0d cycles=%0d", tag, beat, iter);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    build_model();
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", 32'(busy), 32'd0);

    run_scan("full_ready", 0, 1'b0, -1, -1);
    run_scan("toggle_ready", 1, 1'b0, -1, -1);
    run_scan("abort20", 0, 1'b0, 19, -1);
    run_scan("after_abort", 2, 1'b0, -1, -1);
    run_scan("start_held", 0, 1'b1, -1, -1);
    run_scan("mid_reset", 2, 1'b0, -1, 30);
    run_scan("after_reset", 0, 1'b0, -1, -1);
    run_scan("random_ready", 2, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
